// File: rtl/cpu_pkg.sv
// Shared types and constants for the F/D/E/M/W pipeline control blocks.
// Slot widths follow CPU_REG_AW; instantiate blocks with a matching REG_AW.
package cpu_pkg;

    localparam int CPU_REG_AW = 4;
    localparam int CPU_PC_REG = 15;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [CPU_REG_AW-1:0] wa;
        logic                  load;
        logic                  pcs;
    } slot_t;

    // M is the younger producer, so it shadows W.
    function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
        if (hit_m) begin
            return FWD_M;
        end
        if (hit_w) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hz_match.sv
// Purpose: RAW comparator for one source operand against one in-flight slot.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module hz_match
    import cpu_pkg::*;
#(
    parameter int REG_AW = CPU_REG_AW,
    parameter int PC_REG = CPU_PC_REG
) (
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  slot_t             slot,
    output logic              match
);

    localparam logic [REG_AW-1:0] PC_A = REG_AW'(PC_REG);

    // PC reads come from the fetch path, never from a pipeline producer.
    assign match = used & slot.valid & slot.we & (slot.wa == src) & (src != PC_A);

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: hazard unit; tracks E/M/W destinations, drives forwarding, stalls and flushes.
// Latency: outputs combinational from D inputs and slot state; slots/counters update each clk.
// Backpressure: ld_stall holds F/D and bubbles E; pending PC writes hold fetch and flush D.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW = CPU_REG_AW,
    parameter int PC_REG = CPU_PC_REG,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_ra1,
    input  logic [REG_AW-1:0] d_ra2,
    input  logic              d_use1,
    input  logic              d_use2,
    input  logic              d_we,
    input  logic [REG_AW-1:0] d_wa,
    input  logic              d_load,
    input  logic              d_pcs,
    input  logic              e_cancel,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    slot_t             e_slot, m_slot, w_slot;
    slot_t             d_slot, m_next;
    logic [REG_AW-1:0] e_ra1, e_ra2;
    logic              e_use1, e_use2;

    logic [1:0][REG_AW-1:0] d_src, e_src;
    logic [1:0]             d_use, e_use;
    logic [1:0]             hit_de, hit_dm, hit_dw, hit_em, hit_ew;

    logic     ld_stall_raw, ld_stall, pc_pend, br_taken_w;
    fwd_sel_t fwd_a, fwd_b;

    assign d_src = {d_ra2, d_ra1};
    assign d_use = {d_use2 & d_valid, d_use1 & d_valid};
    assign e_src = {e_ra2, e_ra1};
    assign e_use = {e_use2, e_use1};

    generate
        for (genvar k = 0; k < 2; k++) begin : g_src
            hz_match #(.REG_AW(REG_AW), .PC_REG(PC_REG)) u_de (
                .src(d_src[k]), .used(d_use[k]), .slot(e_slot), .match(hit_de[k]));
            hz_match #(.REG_AW(REG_AW), .PC_REG(PC_REG)) u_dm (
                .src(d_src[k]), .used(d_use[k]), .slot(m_slot), .match(hit_dm[k]));
            hz_match #(.REG_AW(REG_AW), .PC_REG(PC_REG)) u_dw (
                .src(d_src[k]), .used(d_use[k]), .slot(w_slot), .match(hit_dw[k]));
            hz_match #(.REG_AW(REG_AW), .PC_REG(PC_REG)) u_em (
                .src(e_src[k]), .used(e_use[k]), .slot(m_slot), .match(hit_em[k]));
            hz_match #(.REG_AW(REG_AW), .PC_REG(PC_REG)) u_ew (
                .src(e_src[k]), .used(e_use[k]), .slot(w_slot), .match(hit_ew[k]));
        end
    endgenerate

    always_comb begin
        ld_stall_raw = 1'b0;
        fwd_a        = FWD_RF;
        fwd_b        = FWD_RF;
        if (FWD_EN != 0) begin
            ld_stall_raw = (|hit_de) & e_slot.load;
            // A load in M has no data yet; it is caught by the load-use stall instead.
            fwd_a = fwd_pick(hit_em[0] & ~m_slot.load, hit_ew[0]);
            fwd_b = fwd_pick(hit_em[1] & ~m_slot.load, hit_ew[1]);
        end else begin
            // W counts too: the regfile write is not visible to a same-cycle read.
            ld_stall_raw = |{hit_de, hit_dm, hit_dw};
        end
    end

    // Reset silences every request combinationally, in the same cycle it is raised.
    assign ld_stall   = ~reset & ld_stall_raw;
    assign pc_pend    = ~reset & ((d_valid & d_pcs) | (e_slot.valid & e_slot.pcs)
                                  | (m_slot.valid & m_slot.pcs));
    assign br_taken_w = ~reset & w_slot.valid & w_slot.pcs;

    assign stall_f = ld_stall | pc_pend;
    assign stall_d = ld_stall;
    assign flush_d = pc_pend | br_taken_w;
    assign flush_e = ld_stall | br_taken_w;
    assign fwd_a_e = reset ? FWD_RF : fwd_a;
    assign fwd_b_e = reset ? FWD_RF : fwd_b;

    always_comb begin
        d_slot       = '0;
        d_slot.valid = d_valid;
        d_slot.we    = d_valid & d_we;
        d_slot.wa    = d_wa;
        d_slot.load  = d_valid & d_load;
        d_slot.pcs   = d_valid & d_pcs;
    end

    always_comb begin
        m_next = e_slot;
        if (e_cancel) begin
            m_next.we  = 1'b0;
            m_next.pcs = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_slot    <= '0;
            m_slot    <= '0;
            w_slot    <= '0;
            e_ra1     <= '0;
            e_ra2     <= '0;
            e_use1    <= 1'b0;
            e_use2    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            w_slot <= m_slot;
            m_slot <= m_next;
            if (flush_e) begin
                e_slot <= '0;
                e_ra1  <= '0;
                e_ra2  <= '0;
                e_use1 <= 1'b0;
                e_use2 <= 1'b0;
            end else begin
                e_slot <= d_slot;
                e_ra1  <= d_ra1;
                e_ra2  <= d_ra2;
                e_use1 <= d_use[0];
                e_use2 <= d_use[1];
            end
            if (ld_stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_d && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // Loads in W have already delivered their data; the flag has no consumer there.
    logic unused_w_load;
    assign unused_w_load = w_slot.load;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl; drives a forwarding and a non-forwarding
// instance from the same D-stage stimulus and checks the selected one per vector.
module tb_hazard_ctrl;

    localparam int CW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, d_valid, d_use1, d_use2, d_we, d_load, d_pcs, e_cancel;
    logic [3:0] d_ra1, d_ra2, d_wa;

    logic          sf1, sd1, fd1, fe1, sf0, sd0, fd0, fe0;
    logic [1:0]    fa1, fb1, fa0, fb0;
    logic [CW-1:0] sc1, fc1, sc0, fc0;

    hazard_ctrl #(.FWD_EN(1), .CNT_W(CW)) dut1 (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_ra1(d_ra1), .d_ra2(d_ra2),
        .d_use1(d_use1), .d_use2(d_use2), .d_we(d_we), .d_wa(d_wa), .d_load(d_load),
        .d_pcs(d_pcs), .e_cancel(e_cancel), .stall_f(sf1), .stall_d(sd1),
        .flush_d(fd1), .flush_e(fe1), .fwd_a_e(fa1), .fwd_b_e(fb1),
        .stall_cnt(sc1), .flush_cnt(fc1));

    hazard_ctrl #(.FWD_EN(0), .CNT_W(CW)) dut0 (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_ra1(d_ra1), .d_ra2(d_ra2),
        .d_use1(d_use1), .d_use2(d_use2), .d_we(d_we), .d_wa(d_wa), .d_load(d_load),
        .d_pcs(d_pcs), .e_cancel(e_cancel), .stall_f(sf0), .stall_d(sd0),
        .flush_d(fd0), .flush_e(fe0), .fwd_a_e(fa0), .fwd_b_e(fb0),
        .stall_cnt(sc0), .flush_cnt(fc0));

    typedef struct packed {
        logic       v;
        logic [3:0] ra1;
        logic       u1;
        logic [3:0] ra2;
        logic       u2;
        logic       we;
        logic [3:0] wa;
        logic       ld;
        logic       pcs;
    } din_t;

    typedef struct {
        logic       rst;
        logic       canc;
        logic       dut;
        din_t       d;
        logic [3:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       ck;
        int         esc;
        int         efc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic din_t ins(int ra1, int u1, int ra2, int u2, int we, int wa,
                                 int ld, int pcs);
        din_t d;
        d.v   = 1'b1;
        d.ra1 = 4'(ra1);
        d.u1  = 1'(u1);
        d.ra2 = 4'(ra2);
        d.u2  = 1'(u2);
        d.we  = 1'(we);
        d.wa  = 4'(wa);
        d.ld  = 1'(ld);
        d.pcs = 1'(pcs);
        return d;
    endfunction

    function automatic vec_t rc(logic rst, logic canc, logic dut, din_t d, logic [3:0] ctl,
                                logic [1:0] fa, logic [1:0] fb, logic ck, int esc, int efc);
        vec_t v;
        v.rst = rst; v.canc = canc; v.dut = dut; v.d = d;
        v.ctl = ctl; v.fa = fa; v.fb = fb;
        v.ck = ck; v.esc = esc; v.efc = efc;
        return v;
    endfunction

    function automatic vec_t r(logic rst, logic canc, logic dut, din_t d, logic [3:0] ctl,
                               logic [1:0] fa, logic [1:0] fb);
        return rc(rst, canc, dut, d, ctl, fa, fb, 1'b0, 0, 0);
    endfunction

    task automatic drive(input din_t d, input logic rst, input logic canc);
        reset    = rst;
        e_cancel = canc;
        d_valid  = d.v;
        d_ra1    = d.ra1;
        d_use1   = d.u1;
        d_ra2    = d.ra2;
        d_use2   = d.u2;
        d_we     = d.we;
        d_wa     = d.wa;
        d_load   = d.ld;
        d_pcs    = d.pcs;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    vec_t vt[$];
    din_t NOP, ADD1, SUB, ORR, LDR, ADD2_11, ADD2_10, BR, BXR1, ADD15, ADD1_15, I3, I4, LDRS;
    logic [7:0] act, exp;

    initial begin
        NOP     = '0;
        ADD1    = ins(2, 1, 3, 1, 1, 1, 0, 0);   // ADD R1,R2,R3
        SUB     = ins(1, 1, 5, 1, 1, 4, 0, 0);   // SUB R4,R1,R5
        ORR     = ins(1, 1, 1, 1, 1, 6, 0, 0);   // ORR R6,R1,R1
        LDR     = ins(0, 1, 0, 0, 1, 1, 1, 0);   // LDR R1,[R0]
        ADD2_11 = ins(1, 1, 1, 1, 1, 2, 0, 0);   // ADD R2,R1,R1
        ADD2_10 = ins(1, 1, 0, 1, 1, 2, 0, 0);   // ADD R2,R1,R0
        BR      = ins(0, 0, 0, 0, 0, 0, 0, 1);   // B label
        BXR1    = ins(1, 1, 0, 0, 0, 0, 0, 1);   // BX R1
        ADD15   = ins(2, 1, 3, 1, 1, 15, 0, 0);  // ADD PC,R2,R3
        ADD1_15 = ins(15, 1, 3, 1, 1, 1, 0, 0);  // ADD R1,PC,R3
        I3      = ins(15, 1, 1, 0, 0, 0, 0, 0);  // reads PC, R1 field unused
        I4      = ins(0, 0, 1, 1, 0, 0, 0, 0);   // CMP-like read of R1
        LDRS    = ins(1, 1, 0, 0, 1, 1, 1, 0);   // LDR R1,[R1]

        // ALU result forwarded from M
        vt.push_back(r (1, 0, 1, NOP,     4'b0000, 2'b00, 2'b00));
        vt.push_back(rc(0, 0, 1, ADD1,    4'b0000, 2'b00, 2'b00, 1, 0, 0));
        vt.push_back(r (0, 0, 1, SUB,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, NOP,     4'b0000, 2'b10, 2'b00));
        vt.push_back(rc(0, 0, 1, NOP,     4'b0000, 2'b00, 2'b00, 1, 0, 0));
        // forwarded from W on both operands
        vt.push_back(r (1, 0, 1, NOP,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, ADD1,    4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, NOP,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, ORR,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, NOP,     4'b0000, 2'b01, 2'b01));
        vt.push_back(rc(0, 0, 1, NOP,     4'b0000, 2'b00, 2'b00, 1, 0, 0));
        // load-use: one stall then W forwarding
        vt.push_back(r (1, 0, 1, NOP,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, LDR,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, ADD2_11, 4'b1101, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, ADD2_11, 4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, NOP,     4'b0000, 2'b01, 2'b01));
        vt.push_back(rc(0, 0, 1, NOP,     4'b0000, 2'b00, 2'b00, 1, 1, 0));
        // no-forwarding instance: three stall cycles
        vt.push_back(r (1, 0, 0, NOP,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 0, ADD1,    4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 0, ADD2_10, 4'b1101, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 0, ADD2_10, 4'b1101, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 0, ADD2_10, 4'b1101, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 0, ADD2_10, 4'b0000, 2'b00, 2'b00));
        vt.push_back(rc(0, 0, 0, NOP,     4'b0000, 2'b00, 2'b00, 1, 3, 0));
        // branch through D, E, M, W
        vt.push_back(r (1, 0, 1, NOP,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, BR,      4'b1010, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, NOP,     4'b1010, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, NOP,     4'b1010, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, NOP,     4'b0011, 2'b00, 2'b00));
        vt.push_back(rc(0, 0, 1, NOP,     4'b0000, 2'b00, 2'b00, 1, 0, 4));
        // branch cancelled in E
        vt.push_back(r (1, 0, 1, NOP,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, BR,      4'b1010, 2'b00, 2'b00));
        vt.push_back(r (0, 1, 1, NOP,     4'b1010, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, NOP,     4'b0000, 2'b00, 2'b00));
        vt.push_back(rc(0, 0, 1, NOP,     4'b0000, 2'b00, 2'b00, 1, 0, 2));
        // reset while a branch is pending
        vt.push_back(r (1, 0, 1, NOP,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, BR,      4'b1010, 2'b00, 2'b00));
        vt.push_back(r (1, 0, 1, NOP,     4'b0000, 2'b00, 2'b00));
        vt.push_back(rc(0, 0, 1, NOP,     4'b0000, 2'b00, 2'b00, 1, 0, 0));
        // load-use and PC write together: all four controls
        vt.push_back(r (1, 0, 1, NOP,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, LDR,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 1, BXR1,    4'b1111, 2'b00, 2'b00));
        vt.push_back(rc(0, 0, 1, NOP,     4'b0000, 2'b00, 2'b00, 1, 1, 1));
        // PC register and unused operands never stall
        vt.push_back(r (1, 0, 0, NOP,     4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 0, ADD15,   4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 0, ADD1_15, 4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 0, I3,      4'b0000, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 0, I4,      4'b1101, 2'b00, 2'b00));
        vt.push_back(r (0, 0, 0, I4,      4'b1101, 2'b00, 2'b00));
        vt.push_back(rc(0, 0, 0, I4,      4'b0000, 2'b00, 2'b00, 1, 2, 0));

        drive(NOP, 1'b1, 1'b0);

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].d, vt[i].rst, vt[i].canc);
            #1;
            act = vt[i].dut ? {sf1, sd1, fd1, fe1, fa1, fb1} : {sf0, sd0, fd0, fe0, fa0, fb0};
            exp = {vt[i].ctl, vt[i].fa, vt[i].fb};
            chk($sformatf("vec%0d ctl/fwd", i), int'(act), int'(exp));
            if (vt[i].ck) begin
                chk($sformatf("vec%0d stall_cnt", i),
                    vt[i].dut ? int'(sc1) : int'(sc0), vt[i].esc);
                chk($sformatf("vec%0d flush_cnt", i),
                    vt[i].dut ? int'(fc1) : int'(fc0), vt[i].efc);
            end
        end

        // Counter saturation: a self-dependent load stalls at least every other cycle.
        @(negedge clk);
        drive(NOP, 1'b1, 1'b0);
        @(negedge clk);
        drive(LDRS, 1'b0, 1'b0);
        repeat (2 * (1 << CW) + 5) @(negedge clk);
        #1;
        chk("sat stall_cnt fwd", int'(sc1), (1 << CW) - 1);
        chk("sat stall_cnt nofwd", int'(sc0), (1 << CW) - 1);
        chk("sat flush_cnt idle", int'(fc1), 0);

        drive(BR, 1'b0, 1'b0);
        repeat ((1 << CW) + 5) @(negedge clk);
        #1;
        chk("sat flush_cnt", int'(fc1), (1 << CW) - 1);
        chk("sat stall_cnt hold", int'(sc1), (1 << CW) - 1);

        // One reset cycle clears counters and every pending branch.
        @(negedge clk);
        drive(NOP, 1'b1, 1'b0);
        #1;
        chk("reset same-cycle ctl", int'({sf1, sd1, fd1, fe1}), 0);
        @(negedge clk);
        drive(NOP, 1'b0, 1'b0);
        #1;
        chk("post-reset stall_cnt", int'(sc1), 0);
        chk("post-reset flush_cnt", int'(fc1), 0);
        chk("post-reset ctl fwd", int'({sf1, sd1, fd1, fe1, fa1, fb1}), 0);
        chk("post-reset ctl nofwd", int'({sf0, sd0, fd0, fe0, fa0, fb0}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
